// File: rtl/spi_master_shifter.sv
// spi_master_shifter: single-word full-duplex SPI master.
// Divided SCLK, registered pins, valid/ready word interface.
module spi_master_shifter #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  spi_sclk,
  output logic                  spi_cs_n,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TOG_LAST = TW'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]         cnt;
  logic [TW-1:0]         tcnt;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] rx_sh;

  logic accept;
  logic tick;
  logic toggle;
  logic lead;
  logic last;
  logic done;
  logic do_sample;
  logic do_shift;

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign accept   = tx_valid && tx_ready;
  assign tick     = (cnt == CNT_MAX);
  assign toggle   = tick &&
                    (state_q == SETUP ||
                     state_q == SHIFT);
  // tcnt holds toggles done so far
  assign lead     = ~tcnt[0];
  assign last     = (tcnt == TOG_LAST);
  assign done     = tick && (state_q == HOLD);

  assign do_sample = toggle &&
                     (CPHA ? !lead : lead);
  assign do_shift  = toggle &&
                     (CPHA ? (lead && tcnt != '0)
                           : (!lead && !last));

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state: SETUP ends with toggle 1,
  // SHIFT ends with toggle 2N
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SETUP;
      SETUP: if (tick) state_d = SHIFT;
      SHIFT: if (tick && last) state_d = HOLD;
      HOLD:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // half-period divider
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       cnt <= '0;
    else if (state_q == IDLE || tick) cnt <= '0;
    else                             cnt <= cnt + CW'(1);
  end

  // sclk toggle counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       tcnt <= '0;
    else if (accept) tcnt <= '0;
    else if (toggle) tcnt <= tcnt + TW'(1);
  end

  // transmit shift register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         sh <= '0;
    else if (accept)   sh <= tx_data;
    else if (do_shift) sh <= {sh[DATA_WIDTH-2:0], 1'b0};
  end

  // receive shift register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      rx_sh <= '0;
    else if (do_sample)
      rx_sh <= {rx_sh[DATA_WIDTH-2:0], spi_miso};
  end

  // chip select
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       spi_cs_n <= 1'b1;
    else if (accept) spi_cs_n <= 1'b0;
    else if (done)   spi_cs_n <= 1'b1;
  end

  // serial clock
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       spi_sclk <= CPOL;
    else if (accept) spi_sclk <= CPOL;
    else if (toggle) spi_sclk <= ~spi_sclk;
  end

  // mosi: MSB on accept, next bit on shift
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         spi_mosi <= 1'b0;
    else if (accept)   spi_mosi <= tx_data[DATA_WIDTH-1];
    else if (do_shift) spi_mosi <= sh[DATA_WIDTH-2];
    else if (done)     spi_mosi <= 1'b0;
  end

  // received word and its one-cycle strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= done;
      if (done) rx_data <= rx_sh;
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
// tb_spi_master_shifter: four configurations checked
// against spec timing and an SPI slave/loopback model.
module tb_spi_master_shifter;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int nb[4]   = '{8, 8, 16, 8};
  int dv[4]   = '{2, 3, 1, 1};
  bit cpol[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  bit cpha[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic [15:0] txd[4];
  logic [15:0] rxd[4];
  logic [3:0]  tx_valid = 4'h0;
  logic [3:0]  tx_ready, rx_valid, busy;
  logic [3:0]  sclk, cs_n, mosi, miso;
  logic [3:0]  loopb   = 4'hF;
  logic [3:0]  sl_miso = 4'h0;
  logic [7:0]  rx0, rx1, rx3;
  logic [15:0] rx2;

  assign miso = (loopb & mosi) | (~loopb & sl_miso);

  always_comb begin
    rxd[0] = {8'h00, rx0};
    rxd[1] = {8'h00, rx1};
    rxd[2] = rx2;
    rxd[3] = {8'h00, rx3};
  end

  spi_master_shifter #(.DATA_WIDTH(8), .CLK_DIV(2),
    .CPOL(1'b0), .CPHA(1'b0)) u0 (
    .clk(clk), .rstn(rstn),
    .tx_data(txd[0][7:0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .rx_data(rx0),
    .rx_valid(rx_valid[0]), .busy(busy[0]),
    .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0]));

  spi_master_shifter #(.DATA_WIDTH(8), .CLK_DIV(3),
    .CPOL(1'b1), .CPHA(1'b1)) u1 (
    .clk(clk), .rstn(rstn),
    .tx_data(txd[1][7:0]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .rx_data(rx1),
    .rx_valid(rx_valid[1]), .busy(busy[1]),
    .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1]));

  spi_master_shifter #(.DATA_WIDTH(16), .CLK_DIV(1),
    .CPOL(1'b0), .CPHA(1'b0)) u2 (
    .clk(clk), .rstn(rstn),
    .tx_data(txd[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .rx_data(rx2),
    .rx_valid(rx_valid[2]), .busy(busy[2]),
    .spi_sclk(sclk[2]), .spi_cs_n(cs_n[2]),
    .spi_mosi(mosi[2]), .spi_miso(miso[2]));

  spi_master_shifter #(.DATA_WIDTH(8), .CLK_DIV(1),
    .CPOL(1'b0), .CPHA(1'b0)) u3 (
    .clk(clk), .rstn(rstn),
    .tx_data(txd[3][7:0]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .rx_data(rx3),
    .rx_valid(rx_valid[3]), .busy(busy[3]),
    .spi_sclk(sclk[3]), .spi_cs_n(cs_n[3]),
    .spi_mosi(mosi[3]), .spi_miso(miso[3]));

  int ntog[4]     = '{default: 0};
  int tog_cyc[4][64];
  int fall_cyc[4] = '{default: 0};
  int rise_cyc[4] = '{default: 0};
  int gap[4]      = '{default: 0};
  int nfall[4]    = '{default: 0};
  int nrxv[4]     = '{default: 0};
  int rxv_cyc[4]  = '{default: 0};
  int mosi_bad[4] = '{default: 0};
  logic [15:0] sl_tx[4];
  logic [15:0] sl_rx[4];
  logic [3:0] pcs   = 4'hF;
  logic [3:0] psclk = 4'b0010;
  logic [3:0] pmosi = 4'h0;

  int n_tests = 0;
  int n_fail  = 0;

  // Pin monitor and SPI slave model, labelled by clk edge.
  always @(negedge clk) begin : mon
    bit lead;
    bit samp;
    for (int u = 0; u < 4; u++) begin
      if (cs_n[u] !== pcs[u]) begin
        if (cs_n[u] === 1'b0) begin
          fall_cyc[u] = cyc;
          gap[u] = cyc - rise_cyc[u];
          ntog[u] = 0;
          nfall[u]++;
          mosi_bad[u] = 0;
          sl_rx[u] = 16'h0;
          if (!cpha[u]) begin
            sl_miso[u] = sl_tx[u][nb[u]-1];
            sl_tx[u] = sl_tx[u] << 1;
          end
        end else begin
          rise_cyc[u] = cyc;
        end
      end
      if (sclk[u] !== psclk[u]) begin
        lead = (psclk[u] == cpol[u]);
        samp = (lead == !cpha[u]);
        if (ntog[u] < 64) tog_cyc[u][ntog[u]] = cyc;
        ntog[u]++;
        if (samp) begin
          if (mosi[u] !== pmosi[u]) mosi_bad[u]++;
          sl_rx[u] = {sl_rx[u][14:0], pmosi[u]};
        end else if (cs_n[u] === 1'b0) begin
          sl_miso[u] = sl_tx[u][nb[u]-1];
          sl_tx[u] = sl_tx[u] << 1;
        end
      end
      if (rx_valid[u] === 1'b1) begin
        nrxv[u]++;
        rxv_cyc[u] = cyc;
      end
      pcs[u]   = cs_n[u];
      psclk[u] = sclk[u];
      pmosi[u] = mosi[u];
    end
  end

  task automatic start_xfer(input int u,
                            input logic [15:0] w,
                            input logic [15:0] sw,
                            input bit lb,
                            output int t);
    @(posedge clk); #1;
    sl_tx[u] = sw;
    loopb[u] = lb;
    txd[u] = w;
    tx_valid[u] = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    tx_valid[u] = 1'b0;
  endtask

  task automatic wait_rxv(input int u, input int base,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk); #1;
      if (nrxv[u] > base) ok = 1'b1;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got, exp;
    repeat (2) @(negedge clk);
    #1;
    for (int u = 0; u < 4; u++) begin
      got = {cs_n[u], sclk[u], mosi[u], busy[u],
             rx_valid[u], tx_ready[u]};
      exp = {1'b1, cpol[u], 4'b0001};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_pins u%0d: got %b expected %b",
                 u, got, exp);
      end
      n_tests++;
      if (rxd[u] !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_rx u%0d: got %h expected 0",
                 u, rxd[u]);
      end
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (tx_ready !== 4'hF || cs_n !== 4'hF) begin
      n_fail++;
      $display("FAIL post_reset_idle: ready %b cs %b expected 1111",
               tx_ready, cs_n);
    end
  endtask

  task automatic test_mode0();
    logic [15:0] w;
    int t, base, bad, d;
    bit ok;
    d = dv[0];
    for (int i = 0; i < 5; i++) begin
      w = (i == 4) ? 16'h00A5 : {8'h00, 8'($urandom)};
      base = nrxv[0];
      start_xfer(0, w, 16'h0, 1'b1, t);
      wait_rxv(0, base, ok);
      bad = 0;
      for (int k = 1; k <= 16; k++)
        if (tog_cyc[0][k-1] != t + 1 + k * d) bad++;
      n_tests++;
      if (!ok || rxd[0] !== w) begin
        n_fail++;
        $display("FAIL m0_rx: got %h expected %h (done=%0d)",
                 rxd[0], w, ok);
      end
      n_tests++;
      if (nrxv[0] - base != 1 || rxv_cyc[0] != t + 35) begin
        n_fail++;
        $display("FAIL m0_rxv: pulses %0d at %0d expected 1 at %0d",
                 nrxv[0] - base, rxv_cyc[0], t + 35);
      end
      n_tests++;
      if (ntog[0] != 16 || bad != 0) begin
        n_fail++;
        $display("FAIL m0_sclk: toggles %0d late %0d expected 16 0",
                 ntog[0], bad);
      end
      n_tests++;
      if (fall_cyc[0] != t + 1 ||
          rise_cyc[0] - fall_cyc[0] != 34) begin
        n_fail++;
        $display("FAIL m0_cs: fall %0d low %0d expected %0d 34",
                 fall_cyc[0], rise_cyc[0] - fall_cyc[0], t + 1);
      end
      n_tests++;
      if (mosi_bad[0] != 0 || sclk[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL m0_mosi_stable: changes %0d sclk %b expected 0 0",
                 mosi_bad[0], sclk[0]);
      end
    end
  endtask

  task automatic test_mode3();
    logic [15:0] w, sw;
    int t, base, bad;
    bit ok;
    logic idle_pre;
    for (int i = 0; i < 4; i++) begin
      w  = (i == 0) ? 16'h00C3 : {8'h00, 8'($urandom)};
      sw = (i == 0) ? 16'h003C : {8'h00, 8'($urandom)};
      base = nrxv[1];
      idle_pre = sclk[1];
      start_xfer(1, w, sw, 1'b0, t);
      wait_rxv(1, base, ok);
      bad = 0;
      for (int k = 1; k <= 16; k++)
        if (tog_cyc[1][k-1] != t + 1 + k * 3) bad++;
      n_tests++;
      if (!ok || rxd[1] !== sw) begin
        n_fail++;
        $display("FAIL m3_rx: got %h expected %h", rxd[1], sw);
      end
      n_tests++;
      if ((sl_rx[1] & 16'h00FF) !== w) begin
        n_fail++;
        $display("FAIL m3_slave: got %h expected %h",
                 sl_rx[1] & 16'h00FF, w);
      end
      n_tests++;
      if (rise_cyc[1] - fall_cyc[1] != 51 || fall_cyc[1] != t + 1) begin
        n_fail++;
        $display("FAIL m3_cs: low %0d fall %0d expected 51 %0d",
                 rise_cyc[1] - fall_cyc[1], fall_cyc[1], t + 1);
      end
      n_tests++;
      if (ntog[1] != 16 || bad != 0 ||
          idle_pre !== 1'b1 || sclk[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL m3_sclk: toggles %0d late %0d idle %b/%b expected 16 0 1/1",
                 ntog[1], bad, idle_pre, sclk[1]);
      end
      n_tests++;
      if (nrxv[1] - base != 1 || mosi_bad[1] != 0) begin
        n_fail++;
        $display("FAIL m3_rxv: pulses %0d mosi changes %0d expected 1 0",
                 nrxv[1] - base, mosi_bad[1]);
      end
    end
  endtask

  task automatic test_wide();
    logic [15:0] w;
    int t, base, bad;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      w = (i == 0) ? 16'hBEEF : 16'($urandom);
      base = nrxv[2];
      start_xfer(2, w, 16'h0, 1'b1, t);
      wait_rxv(2, base, ok);
      bad = 0;
      for (int k = 1; k <= 32; k++)
        if (tog_cyc[2][k-1] != t + 1 + k) bad++;
      n_tests++;
      if (!ok || rxd[2] !== w) begin
        n_fail++;
        $display("FAIL wide_rx: got %h expected %h", rxd[2], w);
      end
      n_tests++;
      if (ntog[2] != 32 || bad != 0 || rise_cyc[2] != t + 34) begin
        n_fail++;
        $display("FAIL wide_timing: toggles %0d late %0d rise %0d expected 32 0 %0d",
                 ntog[2], bad, rise_cyc[2], t + 34);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t, base;
    bit ok;
    base = nrxv[3];
    @(posedge clk); #1;
    loopb[3] = 1'b1;
    txd[3] = 16'h0001;
    tx_valid[3] = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    txd[3] = 16'h0080;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (rx_valid[3] === 1'b1) ok = 1'b1;
    end
    n_tests++;
    if (!ok || rxd[3] !== 16'h0001 || cyc != t + 18) begin
      n_fail++;
      $display("FAIL b2b_first: got %h at %0d expected 0001 at %0d",
               rxd[3], cyc, t + 18);
    end
    n_tests++;
    if (tx_ready[3] !== 1'b1 || cs_n[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap_cycle: ready %b cs %b expected 1 1",
               tx_ready[3], cs_n[3]);
    end
    @(negedge clk); #1;
    n_tests++;
    if (cs_n[3] !== 1'b0 || busy[3] !== 1'b1 || gap[3] != 1) begin
      n_fail++;
      $display("FAIL b2b_second_accept: cs %b busy %b gap %0d expected 0 1 1",
               cs_n[3], busy[3], gap[3]);
    end
    tx_valid[3] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (rx_valid[3] === 1'b1) ok = 1'b1;
    end
    n_tests++;
    if (!ok || rxd[3] !== 16'h0080) begin
      n_fail++;
      $display("FAIL b2b_second: got %h expected 0080", rxd[3]);
    end
    repeat (30) @(negedge clk);
    #1;
    n_tests++;
    if (nrxv[3] - base != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d pulses expected 2",
               nrxv[3] - base);
    end
  endtask

  task automatic test_ignore();
    int t, base, nf, bad;
    bit ok, seen;
    logic rdy;
    base = nrxv[0];
    nf = nfall[0];
    start_xfer(0, 16'h0000, 16'h0, 1'b1, t);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #1;
      if (ntog[0] >= 3) seen = 1'b1;
    end
    @(posedge clk); #1;
    txd[0] = 16'h00FF;
    tx_valid[0] = 1'b1;
    rdy = tx_ready[0];
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    n_tests++;
    if (!seen || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_ready: got %b expected 0 (shift=%0d)",
               rdy, seen);
    end
    bad = 0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (nrxv[0] > base) ok = 1'b1;
      else if (tx_ready[0] !== 1'b0) bad++;
    end
    n_tests++;
    if (!ok || rxd[0] !== 16'h0000 || bad != 0) begin
      n_fail++;
      $display("FAIL ign_rx: got %h ready-early %0d expected 0000 0",
               rxd[0], bad);
    end
    repeat (40) @(negedge clk);
    #1;
    n_tests++;
    if (nfall[0] - nf != 1 || nrxv[0] - base != 1) begin
      n_fail++;
      $display("FAIL ign_extra: xfers %0d pulses %0d expected 1 1",
               nfall[0] - nf, nrxv[0] - base);
    end
  endtask

  task automatic test_async_reset();
    int t, base;
    bit ok, seen;
    logic [4:0] got;
    base = nrxv[0];
    start_xfer(0, 16'h0033, 16'h0, 1'b1, t);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #1;
      if (ntog[0] >= 5) seen = 1'b1;
    end
    #1;
    rstn = 1'b0;
    #1;
    got = {cs_n[0], sclk[0], mosi[0], busy[0], tx_ready[0]};
    n_tests++;
    if (!seen || got !== 5'b10001) begin
      n_fail++;
      $display("FAIL arst_pins: got %b expected 10001", got);
    end
    n_tests++;
    if (rxd[0] !== 16'h0 || rx_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_rx: got %h/%b expected 0000/0",
               rxd[0], rx_valid[0]);
    end
    repeat (3) @(negedge clk);
    #1;
    rstn = 1'b1;
    repeat (50) @(negedge clk);
    #1;
    n_tests++;
    if (nrxv[0] != base) begin
      n_fail++;
      $display("FAIL arst_no_rxv: got %0d pulses expected 0",
               nrxv[0] - base);
    end
    base = nrxv[0];
    start_xfer(0, 16'h005A, 16'h0, 1'b1, t);
    wait_rxv(0, base, ok);
    n_tests++;
    if (!ok || rxd[0] !== 16'h005A ||
        rise_cyc[0] - fall_cyc[0] != 34) begin
      n_fail++;
      $display("FAIL arst_recover: got %h low %0d expected 005a 34",
               rxd[0], rise_cyc[0] - fall_cyc[0]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 4; u++) begin
      txd[u] = 16'h0;
      sl_tx[u] = 16'h0;
      sl_rx[u] = 16'h0;
    end
    test_reset();
    test_mode0();
    test_async_reset();
    test_ignore();
    test_mode3();
    test_back_to_back();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
